// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the game-flow controller.
// Provides the state encoding, the 3-digit BCD score type, the default
// DEAD-state lockout length and the BCD saturation value.
package game_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } game_state_t;
    typedef logic [2:0][3:0] bcd3_t;
    localparam int    DEAD_HOLD_DEFAULT = 65_000_000;
    localparam bcd3_t BCD_MAX           = 12'h999;
endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: signal bundle between the game controller and the datapath.
// master: mouse/collision/pipe event sources, reads controller outputs.
// slave : the controller; consumes events, drives game_rst, the jump pulse,
//         the state code and the BCD scores.
interface game_ctrl_if import game_pkg::*; ;
    logic        mouse_left;
    logic        bird_collision;
    logic        pipe_collision;
    logic        pipe_passed;
    logic        game_rst;
    logic        mouse_left_game;
    game_state_t game_state;
    bcd3_t       score_bcd;
    bcd3_t       high_score_bcd;
    modport master (
        output mouse_left, bird_collision, pipe_collision, pipe_passed,
        input  game_rst, mouse_left_game, game_state, score_bcd, high_score_bcd
    );
    modport slave (
        input  mouse_left, bird_collision, pipe_collision, pipe_passed,
        output game_rst, mouse_left_game, game_state, score_bcd, high_score_bcd
    );
endinterface

// File: rtl/bcd3_counter.sv
// bcd3_counter: 3-digit BCD up-counter saturating at 999.
// clk/rst: clock, synchronous active-high reset to 000.
// clr: clear to 000 (wins over inc); inc: add one; q: registered count.
module bcd3_counter import game_pkg::*; (
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  inc,
    output bcd3_t q
);
    bcd3_t q_q, q_d;
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && q_q != BCD_MAX) begin
            q_d[0] = (q_q[0] == 4'd9) ? 4'd0 : q_q[0] + 4'd1;
            q_d[1] = (q_q[0] != 4'd9) ? q_q[1] : (q_q[1] == 4'd9) ? 4'd0 : q_q[1] + 4'd1;
            q_d[2] = (q_q[0] == 4'd9 && q_q[1] == 4'd9) ? q_q[2] + 4'd1 : q_q[2];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: IDLE/PLAY/DEAD game-flow controller with click detection,
// DEAD-state click lockout, BCD score and high score.
// clk/rst: clock, synchronous active-high reset.
// bus (slave): mouse_left, bird_collision, pipe_collision, pipe_passed in;
//              game_rst, mouse_left_game, game_state, score_bcd,
//              high_score_bcd out (all registered).
module game_ctrl import game_pkg::*; #(
    parameter int DEAD_HOLD_CYCLES = DEAD_HOLD_DEFAULT,
    parameter int HOLD_W           = $clog2(DEAD_HOLD_CYCLES + 1)
) (
    input logic        clk,
    input logic        rst,
    game_ctrl_if.slave bus
);
    game_state_t       state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    bcd3_t             high_q, high_d, score;
    logic              ml_q, mlg_q, mlg_d, grst_q, grst_d;
    logic              click, collide, clr, inc;

    // ml_q resets high so a button held through reset gives no click.
    assign click   = bus.mouse_left & ~ml_q;
    assign collide = bus.bird_collision | bus.pipe_collision;

    always_comb begin
        state_d = state_q;
        hold_d  = (hold_q != '0) ? hold_q - HOLD_W'(1) : hold_q;
        high_d  = high_q;
        mlg_d   = 1'b0;
        clr     = 1'b0;
        inc     = 1'b0;
        case (state_q)
            ST_IDLE: if (click) begin
                state_d = ST_PLAY;
                clr     = 1'b1;
                mlg_d   = 1'b1;
            end
            // Collision wins over both the jump and the score increment.
            ST_PLAY: if (collide) begin
                state_d = ST_DEAD;
                hold_d  = HOLD_W'(DEAD_HOLD_CYCLES);
                high_d  = (score > high_q) ? score : high_q;
            end else begin
                mlg_d = click;
                inc   = bus.pipe_passed;
            end
            ST_DEAD: if (click && hold_q == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // game_rst follows the next state so the bird leaves reset together
        // with the first jump pulse.
        grst_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ml_q    <= 1'b1;
            state_q <= ST_IDLE;
            hold_q  <= '0;
            high_q  <= '0;
            mlg_q   <= 1'b0;
            grst_q  <= 1'b1;
        end else begin
            ml_q    <= bus.mouse_left;
            state_q <= state_d;
            hold_q  <= hold_d;
            high_q  <= high_d;
            mlg_q   <= mlg_d;
            grst_q  <= grst_d;
        end
    end

    bcd3_counter u_score (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (inc),
        .q   (score)
    );

    assign bus.game_rst        = grst_q;
    assign bus.mouse_left_game = mlg_q;
    assign bus.game_state      = state_q;
    assign bus.score_bcd       = score;
    assign bus.high_score_bcd  = high_q;
endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game-flow controller for the flappy-bird datapath, sitting directly upstream of the bird physics block. It converts the raw mouse button level into single-cycle click pulses and runs the IDLE/PLAY/DEAD state machine. It drives the `game_rst` and `mouse_left_game` inputs of the bird physics block and consumes its `collision` output together with the pipe-hit and pipe-passed events. It also keeps the current and high score in 3-digit BCD for the HUD renderer.

## Interface
- `DEAD_HOLD_CYCLES`, default 65_000_000: DEAD-state click lockout, 1 s at 65 MHz; minimum 1.
- `HOLD_W`, default `$clog2(DEAD_HOLD_CYCLES+1)`: hold counter width.

Ports:
- `clk`  in  1  pixel/system clock; rising edge.
- `rst`  in  1  synchronous, active-high.
- `mouse_left`  in  1  left-button level, already synchronous to `clk`.
- `bird_collision`  in  1  level from bird physics: bird hit top/bottom.
- `pipe_collision`  in  1  level from pipe hit detector.
- `pipe_passed`  in  1  one-cycle pulse per pipe cleared.
- `game_rst`  out  1  registered; holds bird physics and pipe generator in reset.
- `mouse_left_game`  out  1  registered one-cycle jump pulse.
- `game_state`  out  2  registered state code (IDLE=0, PLAY=1, DEAD=2).
- `score_bcd`  out  12  registered; 3 BCD digits, `[11:8]` = hundreds.
- `high_score_bcd`  out  12  registered; best score since `rst`.

## Operation
- **Click detect:** `click = mouse_left & ~mouse_left_d`. `mouse_left_d` is `mouse_left` delayed by one cycle and resets to 1. A button already held at reset release yields no click until it is released and pressed again.
- **IDLE:** `game_rst = 1`, `mouse_left_game = 0`. On `click`, go to PLAY and clear score to 0.
  - On that same update, `game_rst` drops to 0 and `mouse_left_game` pulses 1, so the bird physics sees the first jump in the cycle it leaves reset.
- **PLAY:** `game_rst = 0`.
  - `click` gives a one-cycle `mouse_left_game` pulse.
  - `pipe_passed` increments the score as a BCD ripple (9→0 with carry). The score saturates at 999.
  - `bird_collision | pipe_collision` moves to DEAD and loads the hold counter with `DEAD_HOLD_CYCLES`. If `score_bcd > high_score_bcd`, `high_score_bcd <= score_bcd`; a plain unsigned 12-bit compare is valid for BCD.
- **DEAD:** `game_rst = 0`, so bird and pipes freeze where they are displayed. `mouse_left_game = 0`.
  - The hold counter decrements to 0. Clicks are ignored while it is nonzero.
  - A `click` with the counter at 0 goes to IDLE. Score is kept for display until the next IDLE→PLAY.
- **Same-cycle priority in PLAY:** collision beats click (no jump pulse) and beats `pipe_passed` (no increment).
- Collision inputs are ignored outside PLAY. `pipe_passed` is ignored outside PLAY.
- Encoding 3 is illegal and recovers to IDLE on the next edge.

## Timing
- **Reset values:**
  - `game_state` = IDLE and `game_rst` = 1.
  - `mouse_left_game` = 0.
  - `score_bcd` = 0 and `high_score_bcd` = 0.
  - Hold counter = 0 and `mouse_left_d` = 1.
- **Latency:** if `mouse_left` is first sampled high at edge N, then `mouse_left_game`, `game_state` and `game_rst` update at edge N+1.
- `mouse_left_game` is never high for more than one consecutive cycle. A button held down produces exactly one pulse.
- Score updates at the edge after `pipe_passed` is sampled.
- DEAD→IDLE is possible no earlier than `DEAD_HOLD_CYCLES+1` edges after entering DEAD.
- `rst` mid-game overrides everything, reaches the reset values at the next edge, and also clears `high_score_bcd`.

## Structure
- Package `game_pkg`:
  - `game_state_t` enum (`ST_IDLE`, `ST_PLAY`, `ST_DEAD`), 2 bits.
  - `bcd3_t` type as `logic [2:0][3:0]`.
  - `DEAD_HOLD_DEFAULT` constant.
  - `BCD_MAX` constant, value 12'h999.
- Sub-module `bcd3_counter`:
  - Inputs `clk`, `rst`, `clr`, `inc`; output `bcd3_t q`.
  - Saturates at 999; `clr` has priority over `inc`.
- The FSM, edge detector, hold counter and high-score register stay in `game_ctrl`.

## Test plan
All scenarios use `DEAD_HOLD_CYCLES` = 10.

1. **Reset with button held:** reset with `mouse_left=1`, release `rst` → `game_state=0`, `game_rst=1`, no `mouse_left_game` pulse while the button stays held. Then release and press → state 1, `game_rst=0`, and a 1-cycle `mouse_left_game` pulse on the same edge.
2. **Click pulses in PLAY:** button held 50 cycles → exactly one pulse. 5 separate presses → exactly 5 pulses, each 1 cycle after its rising sample.
3. **BCD carry and saturation:** 9 `pipe_passed` → `score=0x009`; one more → `0x010`; 1005 total → `0x999`, with no wrap.
4. **Collision priority:** `pipe_collision`, `click` and `pipe_passed` in the same cycle with score 0x012 → state 2, no jump pulse, score stays 0x012, `high_score=0x012`.
5. **DEAD lockout:** in DEAD, click after 5 cycles → still DEAD. Click after the counter reaches 0 → IDLE with `game_rst=1`. Next click → PLAY with `score=0`, `high_score` retained.
6. **Reset mid-play and illegal-state recovery:**
   - `rst` during PLAY with score 0x007 and `high_score` 0x020 → all outputs at reset values on the next edge.
   - Force `game_state` to 3 → IDLE one edge later.
